serial_alu_ctrl: RTL and testbench

Bit-serial ALU sequencer: it computes a WIDTH-bit ALU operation by driving a single 1-bit ALU slice over WIDTH consecutive cycles, LSB first. It holds the carry between cycles, assembles the result, and derives the status flags. It sits between an issuing controller (start/done handshake) and the 1-bit slice, trading latency for area in the small-datapath builds.

---
 rtl/serial_alu_pkg.sv | 22 ++
 rtl/alu1.sv | 33 +++
 rtl/serial_alu_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_alu_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared opcodes, state encoding and helpers for the bit-serial ALU sequencer.
package serial_alu_pkg;

  localparam logic [2:0] ALU_UADD = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_logic_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu1.sv
// Combinational 1-bit ALU slice. Arithmetic ops invert b when control[0] is set,
// so SUB (and the reserved opcode 1) become a + ~b + cin.
module alu1
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] control,
  output logic       result,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    result = 1'b0;
    cout   = 1'b0;
    b_eff  = b ^ control[0];
    if (is_logic_op(control)) begin
      unique case (control[1:0])
        2'b00:   result = a & b;
        2'b01:   result = a | b;
        2'b10:   result = ~(a | b);
        default: result = a ^ b;
      endcase
    end else begin
      result = a ^ b_eff ^ cin;
      cout   = (a & b_eff) | (a & cin) | (b_eff & cin);
    end
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit op through one alu1 slice, LSB first.
// Optional SERIAL_ALU_ABORT_EN adds an abort input that cancels a running op.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       op_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q;
  logic             nz_q;

  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] res_d;
  logic             fin_cout;
  logic             fin_ovf;
  logic             abort_req;

`ifdef SERIAL_ALU_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  alu1 u_alu1 (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .cin     (carry_q),
    .control (op_q),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  // carry_q still holds the carry into the MSB while the final bit is in the slice.
  always_comb begin
    res_d    = {slice_res, res_q[WIDTH-1:1]};
    fin_cout = 1'b0;
    fin_ovf  = 1'b0;
    if (!is_logic_op(op_q)) begin
      fin_cout = slice_cout;
      fin_ovf  = (op_q == ALU_UADD) ? slice_cout : (carry_q ^ slice_cout);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      nz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= control;
            idx_q   <= '0;
            nz_q    <= 1'b0;
            carry_q <= control[0];
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (abort_req) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_d;
            carry_q <= slice_cout;
            nz_q    <= nz_q | slice_res;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              out      <= res_d;
              carryout <= fin_cout;
              overflow <= fin_ovf;
              zero     <= ~(nz_q | slice_res);
              negative <= slice_res;
              busy     <= 1'b0;
              done     <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Randomized self-checking bench for serial_alu_ctrl against an arithmetic reference model.
module tb_serial_alu_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  control;
`ifdef SERIAL_ALU_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic        negative;

  int checks = 0;
  int failures = 0;

  logic [31:0] e_out;
  logic        e_c;
  logic        e_v;

  serial_alu_ctrl #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .control  (control),
`ifdef SERIAL_ALU_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .out      (out),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    logic [32:0] s;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = s[32];
      end
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = ~(a | b);
      default: r = a ^ b;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_out"}, out, e_out);
    check_eq({tag, "_carryout"}, carryout, e_c);
    check_eq({tag, "_overflow"}, overflow, e_v);
    check_eq({tag, "_zero"}, zero, e_out == 32'd0);
    check_eq({tag, "_negative"}, negative, e_out[31]);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    control = op;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_eq("busy_after_accept", busy, 1'b1);
    check_eq("done_low_after_accept", done, 1'b0);
  endtask

  // Waits for done, optionally pulsing a stray start after glitch_at committed bits.
  task automatic finish_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int glitch_at);
    int cnt = 0;
    while (!done && cnt < 40) begin
      if (cnt == glitch_at) begin
        start = 1'b1;
        A = ~a;
        B = a;
        control = 3'd7;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      cnt++;
      if (cnt == 16) check_eq("out_held_in_run", out, e_out);
    end
    check_eq("latency", cnt, 32);
    model(op, a, b, e_out, e_c, e_v);
    check_outputs("result");
    check_eq("busy_low_in_done", busy, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          seen;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    control = '0;
`ifdef SERIAL_ALU_ABORT_EN
    abort = 1'b0;
`endif
    e_out = '0;
    e_c = 1'b0;
    e_v = 1'b0;
    #1;
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_out", out, 32'd0);
    check_eq("reset_zero", zero, 1'b0);
    check_eq("reset_flags", {carryout, overflow, negative}, 3'b000);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    issue(3'd2, 32'h7FFF_FFFF, 32'h0000_0001);
    finish_op(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, -1);
    check_eq("add_ovf_out", out, 32'h8000_0000);
    check_eq("add_ovf_flags", {overflow, carryout, negative, zero}, 4'b1010);
    @(posedge clock);
    #1;
    check_eq("done_one_cycle", done, 1'b0);

    issue(3'd3, 32'd5, 32'd5);
    finish_op(3'd3, 32'd5, 32'd5, -1);
    check_eq("sub_eq_flags", {zero, carryout, overflow}, 3'b110);

    issue(3'd0, 32'hFFFF_FFFF, 32'd1);
    finish_op(3'd0, 32'hFFFF_FFFF, 32'd1, -1);
    check_eq("uadd_wrap_flags", {carryout, overflow, zero}, 3'b111);

    issue(3'd6, 32'h0F0F_0F0F, 32'h00FF_00FF);
    finish_op(3'd6, 32'h0F0F_0F0F, 32'h00FF_00FF, -1);
    check_eq("nor_out", out, 32'hF000_F000);

    // Stray start at bit 5 must not disturb the running op.
    issue(3'd2, 32'h1234_5678, 32'h0FED_CBA9);
    finish_op(3'd2, 32'h1234_5678, 32'h0FED_CBA9, 5);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (n % 5 == 0) b = a;
      if (n % 7 == 0) a = 32'hFFFF_FFFF;
      if (n % 11 == 0) b = 32'h8000_0000;
      // Zero idle cycles exercises the back-to-back start from DONE.
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
        check_eq("idle_done_low", done, 1'b0);
      end
      issue(op, a, b);
      finish_op(op, a, b, -1);
    end

    // Reset in the middle of a run.
    issue(3'd2, 32'hAAAA_0001, 32'h5555_0002);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    e_out = '0;
    e_c = 1'b0;
    e_v = 1'b0;
    check_eq("midrun_reset_busy", busy, 1'b0);
    check_eq("midrun_reset_done", done, 1'b0);
    check_eq("midrun_reset_out", out, 32'd0);
    check_eq("midrun_reset_flags", {carryout, overflow, zero, negative}, 4'b0000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    check_eq("no_done_after_reset", seen, 0);

`ifdef SERIAL_ALU_ABORT_EN
    issue(3'd4, 32'hFFFF_0000, 32'h0000_FFFF);
    finish_op(3'd4, 32'hFFFF_0000, 32'h0000_FFFF, -1);
    check_eq("and_zero", zero, 1'b1);
    @(posedge clock);
    #1;
    issue(3'd2, 32'h0000_0003, 32'h0000_0004);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(posedge clock);
      #1;
    end
    check_eq("abort_no_done", seen, 0);
    check_outputs("abort_retained");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
